tnn_kwta_li: RTL and testbench

TNN_KWTA_LI -- requirements
Module: tnn_kwta_li

---
 rtl/tnn_pkg.sv | 18 +
 rtl/tnn_kwta_li_pulse_stretch.sv | 30 +++
 rtl/tnn_kwta_li.sv | 134 +++++++++++++
 tb/tb_tnn_kwta_li.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and helpers for the TNN lateral-inhibition (k-WTA) block.
package tnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    FULL,
    DONE
  } li_state_t;

  // Effective winner count: zero means one, anything above kmax saturates.
  function automatic int unsigned k_clamp(input int unsigned k, input int unsigned kmax);
    if (k == 0) return 1;
    if (k > kmax) return kmax;
    return k;
  endfunction

endpackage

// File: rtl/tnn_kwta_li_pulse_stretch.sv
// Per-channel output stretcher: one fire cycle becomes a PULSE_W-cycle pulse.
module li_pulse_stretch #(
  parameter int PULSE_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic fire,
  output logic pulse
);

  localparam int CNTW = $clog2(PULSE_W + 1);

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (fire) begin
      cnt_q <= CNTW'(PULSE_W);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

  assign pulse = (cnt_q != '0);

endmodule

// File: rtl/tnn_kwta_li.sv
// k-winner-take-all lateral inhibition over one gamma wave started by grst.
module tnn_kwta_li
  import tnn_pkg::*;
#(
  parameter int Q       = 16,
  parameter int KMAX    = 4,
  parameter int PULSE_W = 8,
  parameter int WINDOW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       grst,
  input  logic [$clog2(KMAX+1)-1:0]  k_cfg,
  input  logic                       mode,
  input  logic [Q-1:0]               ec_spikes,
  output logic [Q-1:0]               li_out,
  output logic [$clog2(Q+1)-1:0]     win_count,
  output logic [$clog2(WINDOW)-1:0]  first_time,
  output logic                       win_valid
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int CW = $clog2(Q + 1);
  localparam int FW = $clog2(WINDOW);
  localparam int TW = $clog2(WINDOW + 1);

  li_state_t     state_q, state_d;
  logic [TW-1:0] t_q;
  logic [Q-1:0]  prev_q;
  logic [Q-1:0]  mask_q;
  logic [Q-1:0]  rise;
  logic [Q-1:0]  admit;
  logic [CW-1:0] win_cnt_q;
  logic [CW-1:0] cnt_next;
  logic [KW-1:0] k_eff_q;
  logic          mode_q;
  logic [FW-1:0] first_q;
  logic          wave_end;
  logic          first_now;

  assign rise      = ec_spikes & ~prev_q & ~mask_q;
  assign wave_end  = ((state_q == OPEN) || (state_q == FULL)) && (t_q == TW'(WINDOW - 1));
  assign first_now = (win_cnt_q == '0) && (admit != '0);

  // Lowest index first; the remaining-slot budget is ignored in bypass mode.
  always_comb begin
    int unsigned taken;
    int unsigned remaining;
    admit     = '0;
    taken     = 0;
    remaining = (32'(k_eff_q) > 32'(win_cnt_q)) ? 32'(k_eff_q) - 32'(win_cnt_q) : 0;
    if ((state_q == OPEN) && !grst) begin
      for (int unsigned i = 0; i < Q; i++) begin
        if (rise[i] && (mode_q || (taken < remaining))) begin
          admit[i] = 1'b1;
          taken    = taken + 1;
        end
      end
    end
    cnt_next = win_cnt_q + CW'(taken);
  end

  always_comb begin
    state_d = state_q;
    if (grst) begin
      state_d = OPEN;
    end else begin
      case (state_q)
        OPEN: begin
          if (wave_end) state_d = DONE;
          else if (!mode_q && (32'(cnt_next) == 32'(k_eff_q))) state_d = FULL;
        end
        FULL:    if (wave_end) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      t_q        <= '0;
      mask_q     <= '0;
      win_cnt_q  <= '0;
      first_q    <= '0;
      k_eff_q    <= KW'(1);
      mode_q     <= 1'b0;
      win_count  <= '0;
      first_time <= '0;
      win_valid  <= 1'b0;
    end else begin
      prev_q    <= ec_spikes;
      win_valid <= 1'b0;
      if (grst) begin
        t_q       <= '0;
        mask_q    <= '0;
        win_cnt_q <= '0;
        first_q   <= '0;
        k_eff_q   <= KW'(k_clamp(32'(k_cfg), KMAX));
        mode_q    <= mode;
      end else begin
        if ((state_q == OPEN) || (state_q == FULL)) t_q <= t_q + TW'(1);
        mask_q    <= mask_q | admit;
        win_cnt_q <= cnt_next;
        if (first_now) first_q <= FW'(t_q);
        // Latch from next-values so a spike admitted on the last wave cycle still counts.
        if (wave_end) begin
          win_valid  <= 1'b1;
          win_count  <= cnt_next;
          first_time <= first_now ? FW'(t_q) : first_q;
        end
      end
    end
  end

  for (genvar g = 0; g < Q; g++) begin : g_stretch
    li_pulse_stretch #(
      .PULSE_W(PULSE_W)
    ) u_stretch (
      .clk  (clk),
      .rst  (rst),
      .clr  (grst),
      .fire (admit[g]),
      .pulse(li_out[g])
    );
  end

endmodule

// File: tb/tb_tnn_kwta_li.sv
// Self-checking bench for tnn_kwta_li against a wave-level behavioural model.
module tb_tnn_kwta_li;

  localparam int Q       = 16;
  localparam int KMAX    = 4;
  localparam int PULSE_W = 8;
  localparam int WINDOW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          grst;
  logic [2:0]    k_cfg;
  logic          mode;
  logic [Q-1:0]  ec_spikes;
  logic [Q-1:0]  li_out;
  logic [4:0]    win_count;
  logic [3:0]    first_time;
  logic          win_valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit           m_active;
  int           m_t;
  bit           m_win[Q];
  int           m_left[Q];
  int           m_nwin;
  int           m_k;
  bit           m_byp;
  int           m_first;
  logic [Q-1:0] m_prev;
  bit           m_wv;
  int           m_cnt_l;
  int           m_first_l;

  tnn_kwta_li #(
    .Q(Q), .KMAX(KMAX), .PULSE_W(PULSE_W), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .rst(rst), .grst(grst), .k_cfg(k_cfg), .mode(mode),
    .ec_spikes(ec_spikes), .li_out(li_out), .win_count(win_count),
    .first_time(first_time), .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_active = 0; m_t = 0; m_nwin = 0; m_k = 1; m_byp = 0; m_first = 0;
    m_prev = '0; m_wv = 0; m_cnt_l = 0; m_first_l = 0;
    for (int i = 0; i < Q; i++) begin m_win[i] = 0; m_left[i] = 0; end
  endfunction

  function automatic void m_edge(input bit g, input int kc, input bit md, input logic [Q-1:0] s);
    m_wv = 0;
    if (g) begin
      m_active = 1; m_t = 0; m_nwin = 0; m_first = 0; m_byp = md;
      m_k = (kc == 0) ? 1 : ((kc > KMAX) ? KMAX : kc);
      for (int i = 0; i < Q; i++) begin m_win[i] = 0; m_left[i] = 0; end
    end else begin
      for (int i = 0; i < Q; i++) if (m_left[i] > 0) m_left[i]--;
      if (m_active) begin
        for (int i = 0; i < Q; i++) begin
          if (s[i] && !m_prev[i] && !m_win[i] && (m_byp || m_nwin < m_k)) begin
            m_win[i]  = 1;
            m_left[i] = PULSE_W;
            if (m_nwin == 0) m_first = m_t;
            m_nwin++;
          end
        end
        if (m_t == WINDOW - 1) begin
          m_wv = 1; m_cnt_l = m_nwin; m_first_l = m_first; m_active = 0;
        end
        m_t++;
      end
    end
    m_prev = s;
  endfunction

  function automatic logic [Q-1:0] m_li();
    logic [Q-1:0] r;
    for (int i = 0; i < Q; i++) r[i] = (m_left[i] > 0);
    return r;
  endfunction

  task automatic compare_all();
    check("li_out", 32'(li_out), 32'(m_li()));
    check("win_valid", 32'(win_valid), 32'(m_wv));
    check("win_count", 32'(win_count), 32'(m_cnt_l));
    check("first_time", 32'(first_time), 32'(m_first_l));
  endtask

  task automatic step(input bit g, input logic [Q-1:0] s);
    @(negedge clk);
    grst      = g;
    ec_spikes = s;
    @(posedge clk);
    m_edge(g, int'(k_cfg), mode, s);
    #1 compare_all();
  endtask

  task automatic start_wave(input int kc, input bit md, input logic [Q-1:0] s);
    k_cfg = 3'(kc);
    mode  = md;
    step(1'b1, s);
  endtask

  function automatic logic [Q-1:0] bits(input int a, input int b = -1, input int c = -1,
                                        input int d = -1, input int e = -1, input int f = -1);
    logic [Q-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    if (e >= 0) r[e] = 1'b1;
    if (f >= 0) r[f] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [Q-1:0] s;
    rst = 1'b1; grst = 1'b0; k_cfg = 3'd1; mode = 1'b0; ec_spikes = '0;
    m_reset();
    #1 compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Inert before the first grst
    for (int i = 0; i < 4; i++) step(1'b0, 16'(i * 16'h1111 + 16'h0101));
    check("pre_grst_quiet", 32'(li_out), 32'h0);

    // k=1, neurons 5 and 9 rise together at t=3
    start_wave(1, 0, '0);
    for (int t = 0; t < WINDOW; t++) begin
      step(1'b0, (t >= 3 && t <= 5) ? bits(5, 9) : '0);
      if (t == 3) check("k1_first_out", 32'(li_out), 32'(bits(5)));
    end
    check("k1_valid", 32'(win_valid), 32'h1);
    check("k1_count", 32'(win_count), 32'd1);
    check("k1_first", 32'(first_time), 32'd3);
    step(1'b0, '0);
    check("k1_valid_single", 32'(win_valid), 32'h0);

    // k=3: neuron 2 at t=1, {4,7,11} at t=2, neuron 0 later
    start_wave(3, 0, '0);
    for (int t = 0; t < WINDOW; t++) begin
      s = '0;
      if (t >= 1) s = s | bits(2);
      if (t >= 2) s = s | bits(4, 7, 11);
      if (t >= 6) s = s | bits(0);
      step(1'b0, s);
      if (t == 6) check("k3_mask", 32'(li_out), 32'(bits(2, 4, 7)));
    end
    check("k3_count", 32'(win_count), 32'd3);
    check("k3_first", 32'(first_time), 32'd1);

    // k_cfg=0 acts as 1
    start_wave(0, 0, '0);
    for (int t = 0; t < WINDOW; t++) step(1'b0, (t == 2) ? bits(10) : '0);
    check("k0_count", 32'(win_count), 32'd1);
    check("k0_first", 32'(first_time), 32'd2);

    // k_cfg=7 clamps to KMAX with lowest indices winning
    start_wave(7, 0, '0);
    for (int t = 0; t < WINDOW; t++) begin
      step(1'b0, (t == 4) ? bits(1, 3, 5, 8, 12, 14) : '0);
      if (t == 4) check("k7_lowest", 32'(li_out), 32'(bits(1, 3, 5, 8)));
    end
    check("k7_count", 32'(win_count), 32'd4);

    // Bypass: all six spikes pass
    start_wave(1, 1, '0);
    for (int t = 0; t < WINDOW; t++) begin
      step(1'b0, (t == 5) ? bits(0, 3, 6, 9, 12, 15) : '0);
      if (t == 5) check("bypass_all", 32'(li_out), 32'(bits(0, 3, 6, 9, 12, 15)));
    end
    check("bypass_count", 32'(win_count), 32'd6);

    // grst mid-wave with neuron 8 held high across it
    start_wave(4, 0, '0);
    for (int t = 0; t < 6; t++) step(1'b0, (t >= 2) ? bits(8) : '0);
    start_wave(4, 0, bits(8));
    check("regrst_clear", 32'(li_out), 32'h0);
    for (int t = 0; t < WINDOW; t++) step(1'b0, bits(8));
    check("held_count", 32'(win_count), 32'd0);
    check("held_first", 32'(first_time), 32'd0);
    // grst while DONE
    start_wave(2, 0, '0);
    check("done_grst_novalid", 32'(win_valid), 32'h0);
    for (int t = 0; t < 4; t++) step(1'b0, (t == 1) ? bits(13) : '0);

    // Asynchronous reset mid-pulse, then inert without grst
    start_wave(2, 0, '0);
    for (int t = 0; t < 7; t++) step(1'b0, (t >= 1) ? bits(3) : '0);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("rst_li_out", 32'(li_out), 32'h0);
    check("rst_count", 32'(win_count), 32'h0);
    check("rst_valid", 32'(win_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) begin rst = 1'b0; ec_spikes = '0; grst = 1'b0; end
    for (int i = 0; i < 6; i++) step(1'b0, (i % 2 == 1) ? 16'hA5C3 : '0);
    check("post_rst_quiet", 32'(li_out), 32'h0);

    // Randomized waves
    for (int w = 0; w < 40; w++) begin
      int len;
      start_wave(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 16'($urandom));
      len = int'($urandom_range(8, WINDOW + 3));
      for (int t = 0; t < len; t++) begin
        s = 16'($urandom & $urandom);
        if ($urandom_range(0, 40) == 0) start_wave(int'($urandom_range(0, 7)), 1'($urandom), s);
        else step(1'b0, s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
